// File: rtl/demux_striping_pkg.sv
// Shared definitions for the N-lane byte-striping demultiplexer.
package demux_striping_pkg;

    localparam int          DEF_DATA_W    = 32;
    localparam int          DEF_MAX_LANES = 4;
    localparam logic [31:0] DEF_PAD       = 32'h0000_0000;

    typedef enum logic [2:0] {
        LM_X1  = 3'd0,
        LM_X2  = 3'd1,
        LM_X4  = 3'd2,
        LM_X8  = 3'd3,
        LM_X16 = 3'd4
    } lane_mode_e;

    // Requested lane count 2**mode, limited to the physical lane count.
    function automatic int lanes_from_mode(input logic [2:0] mode, input int max_lanes);
        int n;
        n = 1 << mode;
        return (n > max_lanes) ? max_lanes : n;
    endfunction

endpackage

// File: rtl/striping_lane_ptr.sv
// Lane pointer and stripe-boundary control for the striping demux.
// Tracks how many words of the current stripe are held, latches the lane
// count at the first word of a stripe, and decodes release conditions.
module striping_lane_ptr
    import demux_striping_pkg::*;
#(
    parameter int MAX_LANES = DEF_MAX_LANES,
    localparam int PW = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1,
    localparam int CW = $clog2(MAX_LANES + 1)
) (
    input  logic          clk_nf,
    input  logic          reset,
    input  logic          valid_in,
    input  logic          flush,
    input  logic [2:0]    lane_mode,
    output logic [PW-1:0] ptr,
    output logic [CW-1:0] eff,
    output logic          rel,
    output logic [CW-1:0] fill_count,
    output logic          busy
);

    logic [CW-1:0] act;
    logic          complete;

    // Lane count is only re-sampled at a stripe boundary; mid-stripe the latched count wins.
    always_comb begin
        eff        = (ptr == '0) ? CW'(lanes_from_mode(lane_mode, MAX_LANES)) : act;
        complete   = valid_in && (CW'(ptr) == eff - CW'(1));
        fill_count = CW'(ptr) + CW'(valid_in);
        rel        = complete || (flush && (fill_count != '0));
    end

    // Pointer advance / wrap, lane-count latch and busy flag.
    always_ff @(posedge clk_nf or posedge reset) begin
        if (reset) begin
            ptr  <= '0;
            act  <= CW'(1);
            busy <= 1'b0;
        end else begin
            if (valid_in && (ptr == '0))
                act <= eff;
            if (rel) begin
                ptr  <= '0;
                busy <= 1'b0;
            end else if (valid_in) begin
                ptr  <= ptr + PW'(1);
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_striping_n.sv
// N-lane round-robin striping demultiplexer. Words are staged until a stripe
// is complete (or flushed) and then released to all lanes on the same edge so
// the lanes stay word-aligned.
module demux_striping_n
    import demux_striping_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                MAX_LANES = DEF_MAX_LANES,
    parameter logic [DATA_W-1:0] PAD       = DATA_W'(DEF_PAD)
) (
    input  logic                        clk_nf,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           data_input,
    input  logic                        valid_in,
    input  logic [2:0]                  lane_mode,
    input  logic                        flush,
    output logic [MAX_LANES*DATA_W-1:0] lane_data,
    output logic [MAX_LANES-1:0]        lane_valid,
    output logic                        busy
);

    localparam int PW = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;
    localparam int CW = $clog2(MAX_LANES + 1);
    localparam int SW = (MAX_LANES > 1) ? MAX_LANES - 1 : 1;

    logic [PW-1:0]     ptr;
    logic [CW-1:0]     eff;
    logic              rel;
    logic [CW-1:0]     fill_count;
    logic [DATA_W-1:0] stage [SW];
    logic [DATA_W-1:0] cand  [MAX_LANES];

    striping_lane_ptr #(
        .MAX_LANES (MAX_LANES)
    ) u_ptr (
        .clk_nf     (clk_nf),
        .reset      (reset),
        .valid_in   (valid_in),
        .flush      (flush),
        .lane_mode  (lane_mode),
        .ptr        (ptr),
        .eff        (eff),
        .rel        (rel),
        .fill_count (fill_count),
        .busy       (busy)
    );

    // Per-lane release candidate: staged word, or the incoming word at the pointer slot.
    always_comb begin
        for (int i = 0; i < MAX_LANES; i++) begin
            cand[i] = '0;
            if (i < SW)
                cand[i] = stage[i];
            if (valid_in && (PW'(i) == ptr))
                cand[i] = data_input;
        end
    end

    // Staging of non-final words and registered release of a stripe onto the lanes.
    always_ff @(posedge clk_nf or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SW; i++)
                stage[i] <= '0;
            lane_data  <= '0;
            lane_valid <= '0;
        end else begin
            if (valid_in && (CW'(ptr) < eff - CW'(1))) begin
                for (int i = 0; i < SW; i++)
                    if (PW'(i) == ptr)
                        stage[i] <= data_input;
            end
            lane_valid <= '0;
            if (rel) begin
                for (int i = 0; i < MAX_LANES; i++) begin
                    if (CW'(i) < fill_count) begin
                        lane_data[i*DATA_W +: DATA_W] <= cand[i];
                        lane_valid[i]                 <= 1'b1;
                    end else begin
                        lane_data[i*DATA_W +: DATA_W] <= PAD;
                    end
                end
            end
        end
    end

endmodule

// File: doc/demux_striping_n.md
Name: demux_striping_n

Overview:
- Parametrised N-lane byte-striping demultiplexer for the PCIe-style physical layer.
- Sits after the fast-clock data path and ahead of the per-lane serialisers.
- Distributes consecutive valid words round-robin across a runtime-selectable number of active lanes (x1/x2/x4/...).
- Releases each completed stripe to all active lanes on the same cycle, so lanes stay aligned. It also supports explicit flush of a partial stripe with padding.

Parameters:
- DATA_W, 32, width of one word and of each lane.
- MAX_LANES, 4, physical lane count; power of two, 1..16.
- PAD, 32'h0000_0000, value driven on lanes that are unfilled or inactive in a released stripe; DATA_W bits.

Ports:
- clk_nf  in  1  fast word clock (N x lane rate); all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_input  in  DATA_W  word to stripe.
- valid_in  in  1  data_input is valid this cycle; a word is accepted on every rising edge with valid_in=1 (no backpressure).
- lane_mode  in  3  active lanes = 2**lane_mode, clamped to MAX_LANES.
- flush  in  1  release the pending partial stripe.
- lane_data  out  MAX_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- lane_valid  out  MAX_LANES  per-lane valid, pulsed on stripe release.
- busy  out  1  partial stripe pending (ptr != 0).

Behaviour:
- State:
  - ptr: lane pointer, 0..MAX_LANES-1.
  - act: latched active lane count.
  - stage: MAX_LANES-1 staging words.
  - Registered lane_data/lane_valid.
- Reset (async, while high): ptr=0, act=1, stage=0, lane_data=0, lane_valid=0, busy=0.
- Effective lane count: eff = clamp(2**lane_mode) when ptr==0, else act. act <= eff on acceptance of a word at ptr==0.
- lane_mode changes while ptr!=0 are ignored until the next stripe boundary.
- Accept with flush=0 and ptr < eff-1: stage[ptr] <= data_input, ptr <= ptr+1. lane_valid <= 0; lane_data holds.
- Accept with flush=0 and ptr == eff-1 (stripe complete):
  - Lanes 0..eff-2 <= stage, lane eff-1 <= data_input, all with valid=1.
  - Lanes >= eff <= PAD, valid=0.
  - ptr <= 0.
- Latency: the word completing a stripe is accepted at edge k. All lanes of that stripe are visible at lane_data from edge k, and lane_valid is high for exactly one cycle.
- x1 mode (eff=1): every accepted word releases immediately on lane 0; lane_valid=...0001 each such cycle.
- valid_in=0 and flush=0: ptr and stage hold; lane_valid <= 0; lane_data holds the last released stripe.
- flush=1 with ptr!=0 (after including any word accepted the same cycle):
  - If that word completes the stripe, perform a normal release.
  - Otherwise release lanes 0..p-1 from stage/incoming with valid=1, where p = filled count. Lanes p..MAX_LANES-1 <= PAD, valid=0. ptr <= 0.
- flush=1 with ptr==0:
  - Accepting a word in x1 gives a normal release.
  - Accepting a word with eff>1 releases that word alone on lane 0, the rest PAD.
  - With no word accepted, flush is a no-op and lane_valid=0.
- busy = (ptr != 0), registered alongside ptr.
- Reset asserted mid-stripe: staged words are discarded, no release, outputs return to reset values immediately.
- lane_mode values >= log2(MAX_LANES) all select MAX_LANES.

Decomposition:
- Shared package demux_striping_pkg:
  - Default DATA_W/MAX_LANES/PAD.
  - Lane-mode encodings LM_X1=0, LM_X2=1, LM_X4=2, LM_X8=3, LM_X16=4.
  - clamp function lanes_from_mode(mode, max).
- One natural sub-module: striping_lane_ptr.
  - Contains the pointer/act register, eff computation, complete and flush decode.
  - Outputs ptr, eff, release, fill_count.
- Top holds the stage and output registers.

Test Plan:
- x4 (lane_mode=2, MAX_LANES=4), words A0..A7 back-to-back -> edge 4: lanes {A3,A2,A1,A0} valid=1111; edge 8: {A7,A6,A5,A4} valid=1111; other cycles valid=0000, busy=1 after words 1-3.
- x2 with valid_in gaps: words B0, idle x3, B1 -> lanes 0/1 = B0/B1 valid=0011 only on B1's edge, lanes 2/3 = PAD; nothing released during gap.
- x4, words C0,C1 then flush=1 with valid_in=0 -> lanes {PAD,PAD,C1,C0} valid=0011, busy=0 next cycle; next word starts at lane 0.
- Mode change mid-stripe: x4, words D0,D1, switch lane_mode=0, words D2,D3 -> single x4 release {D3..D0}; following word D4 releases alone on lane 0, valid=0001.
- x1 stream E0..E2 -> lane 0 = E0,E1,E2 on consecutive edges, valid=0001 each; lanes 1-3 = PAD.
- Reset asserted after 3 words of x4 stripe -> lane_valid=0, lane_data=0, busy=0 asynchronously; after release, F0..F3 -> clean {F3..F0} release, no stale data.
